// File: rtl/dds_pkg.sv
// Shared constants, state encoding and address clamp for the DDS
// frequency-update path.
package dds_pkg;

    localparam int FTW_W    = 32;
    localparam int ADDR_W   = 11;
    localparam int MAX_ADDR = 1800;
    localparam int FTW_STEP = 1790;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MUL       = 2'd1,
        WAIT_WRAP = 2'd2,
        LOAD      = 2'd3
    } state_t;

    function automatic logic [ADDR_W-1:0] clamp_addr(
        input logic [ADDR_W-1:0] a,
        input int unsigned       lim
    );
        return (32'(a) > lim) ? ADDR_W'(lim) : a;
    endfunction

endpackage

// File: rtl/dds_ftw_ctrl_mul.sv
// ftw_mul: 11-cycle LSB-first serial shift-add multiply of the
// frequency address by the per-LSB tuning step.
module ftw_mul
    import dds_pkg::*;
#(
    parameter int STEP = dds_pkg::FTW_STEP
)(
    input  logic              Fg_CLK,
    input  logic              RESETn,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    output logic              done,
    output logic [FTW_W-1:0]  product
);

    localparam logic [3:0] LAST = 4'(ADDR_W - 1);

    logic [3:0]       bit_cnt;
    logic             run;
    logic [FTW_W-1:0] acc;

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            acc     <= '0;
            bit_cnt <= '0;
            run     <= 1'b0;
        end else if (start) begin
            acc     <= '0;
            bit_cnt <= '0;
            run     <= 1'b1;
        end else if (run) begin
            if (addr[bit_cnt])
                acc <= acc + (FTW_W'(STEP) << bit_cnt);
            if (bit_cnt == LAST) begin
                bit_cnt <= '0;
                run     <= 1'b0;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // High while the final step is being applied.
    assign done    = run && (bit_cnt == LAST);
    assign product = acc;

endmodule

// File: rtl/dds_ftw_ctrl.sv
// DDS frequency-update controller: address -> FTW with optional
// wrap-aligned commit (DDS_PHASE_SYNC_EN).
module dds_ftw_ctrl
    import dds_pkg::*;
#(
    parameter int FTW_STEP     = dds_pkg::FTW_STEP,
    parameter int MAX_ADDR     = dds_pkg::MAX_ADDR,
    parameter int WRAP_TIMEOUT = 2400000
)(
    input  logic              Fg_CLK,
    input  logic              RESETn,
    input  logic [ADDR_W-1:0] Address,
    input  logic              FreqChng,
    input  logic              Acc_Wrap,
    output logic [FTW_W-1:0]  FTW,
    output logic              FTW_Load,
    output logic              Busy
);

    state_t            state, state_nxt;
    logic              start, commit, restart;
    logic              mul_done;
    logic [FTW_W-1:0]  product;
    logic [ADDR_W-1:0] addr_q, pend_addr, req_addr;
    logic              pend_v;
    logic              wrap_hit;

    assign req_addr = clamp_addr(Address, MAX_ADDR);
    assign restart  = commit && pend_v;
    assign Busy     = (state != IDLE);

    ftw_mul #(.STEP(FTW_STEP)) u_mul (
        .Fg_CLK  (Fg_CLK),
        .RESETn  (RESETn),
        .start   (start),
        .addr    (addr_q),
        .done    (mul_done),
        .product (product)
    );

`ifdef DDS_PHASE_SYNC_EN
    logic [31:0] tmo_cnt;

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn)
            tmo_cnt <= '0;
        else if (state != WAIT_WRAP)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 32'd1;
    end

    assign wrap_hit = Acc_Wrap || (tmo_cnt == 32'(WRAP_TIMEOUT - 1));
`else
    logic unused_wrap;
    assign unused_wrap = ^{Acc_Wrap, WRAP_TIMEOUT[0]};
    assign wrap_hit    = 1'b0;
`endif

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (FreqChng) begin
                    start     = 1'b1;
                    state_nxt = MUL;
                end
            end
            MUL: begin
`ifdef DDS_PHASE_SYNC_EN
                if (mul_done) state_nxt = WAIT_WRAP;
`else
                if (mul_done) state_nxt = LOAD;
`endif
            end
            WAIT_WRAP: commit = wrap_hit;
            LOAD:      commit = 1'b1;
            default:   state_nxt = IDLE;
        endcase
        if (commit) begin
            start     = pend_v;
            state_nxt = pend_v ? MUL : IDLE;
        end
    end

    // A new request in the restart cycle wins over clearing pend_v.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            addr_q    <= '0;
            pend_addr <= '0;
            pend_v    <= 1'b0;
        end else begin
            if (state == IDLE && FreqChng)
                addr_q <= req_addr;
            else if (restart)
                addr_q <= pend_addr;
            if (FreqChng && state != IDLE) begin
                pend_addr <= req_addr;
                pend_v    <= 1'b1;
            end else if (restart) begin
                pend_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            FTW      <= '0;
            FTW_Load <= 1'b0;
        end else begin
            if (commit) FTW <= product;
            FTW_Load <= commit;
        end
    end

endmodule

// File: tb/tb_dds_ftw_ctrl.sv
// Scoreboard bench for dds_ftw_ctrl; covers both commit modes
// depending on DDS_PHASE_SYNC_EN.
module tb_dds_ftw_ctrl;

    localparam int TMO = 3000;
`ifdef DDS_PHASE_SYNC_EN
    localparam int LAT = 11 + TMO;
`else
    localparam int LAT = 12;
`endif

    logic        Fg_CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic [10:0] Address = '0;
    logic        FreqChng = 1'b0;
    logic        Acc_Wrap = 1'b0;
    logic [31:0] FTW;
    logic        FTW_Load;
    logic        Busy;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_load = 0;
    int          last_load = 0;
    logic [31:0] sb[$];

    dds_ftw_ctrl #(.WRAP_TIMEOUT(TMO)) dut (
        .Fg_CLK   (Fg_CLK),
        .RESETn   (RESETn),
        .Address  (Address),
        .FreqChng (FreqChng),
        .Acc_Wrap (Acc_Wrap),
        .FTW      (FTW),
        .FTW_Load (FTW_Load),
        .Busy     (Busy)
    );

    always #20 Fg_CLK = ~Fg_CLK;

    always @(posedge Fg_CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(posedge Fg_CLK) begin
        #1;
        if (FTW_Load) begin
            n_load++;
            last_load = cyc;
            if (sb.size() == 0)
                chk("spurious_load", 32'(FTW_Load), 32'd0);
            else
                chk("ftw", FTW, sb.pop_front());
        end
    end

    task automatic fire(input logic [10:0] a, output int n);
        @(posedge Fg_CLK);
        #1;
        Address  = a;
        FreqChng = 1'b1;
        n        = cyc + 1;
        @(posedge Fg_CLK);
        #1;
        FreqChng = 1'b0;
    endtask

    task automatic wait_load(input int target, input int budget);
        int i = 0;
        while (n_load < target && i < budget) begin
            @(posedge Fg_CLK);
            #2;
            i++;
        end
        chk("load_cnt", 32'(n_load), 32'(target));
    endtask

    function automatic logic [31:0] model(input logic [10:0] a);
        int unsigned c;
        c = (a > 11'd1800) ? 1800 : int'(a);
        return 32'(c * 1790);
    endfunction

    initial begin
        #(4000000 * 1ns);
        $display("FAIL watchdog got=%0d exp=0", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        logic [10:0] tbl [5];
        tbl = '{11'd2047, 11'd0, 11'd1800, 11'd1023, 11'd1};

        #50;
        chk("rst_ftw", FTW, 32'd0);
        chk("rst_load", 32'(FTW_Load), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        @(posedge Fg_CLK);
        #1;
        RESETn = 1'b1;

        // Basic request with a wrap pulse during MUL that must be ignored.
        base = n_load;
        sb.push_back(32'd179000);
        fire(11'd100, n);
        @(posedge Fg_CLK);
        #1;
        chk("busy_n1", 32'(Busy), 32'd1);
        Acc_Wrap = 1'b1;
        @(posedge Fg_CLK);
        #1;
        Acc_Wrap = 1'b0;
        repeat (LAT - 3) @(posedge Fg_CLK);
        #1;
        chk("busy_pre", 32'(Busy), 32'd1);
        chk("no_early", 32'(n_load), 32'(base));
        wait_load(base + 1, LAT + 20);
        chk("lat100", 32'(last_load - n), 32'(LAT));
        chk("busy_end", 32'(Busy), 32'd0);
        @(posedge Fg_CLK);
        #2;
        chk("load_1cyc", 32'(FTW_Load), 32'd0);

        foreach (tbl[k]) begin
            base = n_load;
            sb.push_back(model(tbl[k]));
            fire(tbl[k], n);
            wait_load(base + 1, LAT + 20);
            chk("lat_tbl", 32'(last_load - n), 32'(LAT));
        end

        // Three requests back to back; only first and last commit.
        base = n_load;
        sb.push_back(32'd17900);
        sb.push_back(32'd53700);
        fire(11'd10, n);
        fire(11'd20, base);
        base = n_load;
        fire(11'd30, base);
        base = n_load;
        wait_load(base + 2, 2 * LAT + 20);
        chk("lat_pend", 32'(last_load - n), 32'(2 * LAT));
        repeat (20) @(posedge Fg_CLK);
        #2;
        chk("pend_cnt", 32'(n_load), 32'(base + 2));
        chk("sb_empty", 32'(sb.size()), 32'd0);

`ifdef DDS_PHASE_SYNC_EN
        base = n_load;
        sb.push_back(32'd895000);
        fire(11'd500, n);
        repeat (49) @(posedge Fg_CLK);
        #1;
        chk("wrap_wait", 32'(n_load), 32'(base));
        Acc_Wrap = 1'b1;
        @(posedge Fg_CLK);
        #1;
        Acc_Wrap = 1'b0;
        wait_load(base + 1, 20);
        chk("wrap_edge", 32'(last_load - n), 32'd51);
`endif

        // Reset mid-MUL with a request pending.
        base = n_load;
        sb.push_back(32'd17900);
        fire(11'd10, n);
        wait_load(base + 1, LAT + 20);
        fire(11'd20, n);
        fire(11'd30, n);
        @(posedge Fg_CLK);
        #5;
        RESETn = 1'b0;
        #1;
        chk("rst_mid_ftw", FTW, 32'd0);
        chk("rst_mid_busy", 32'(Busy), 32'd0);
        chk("rst_mid_load", 32'(FTW_Load), 32'd0);
        repeat (2) @(posedge Fg_CLK);
        #1;
        RESETn = 1'b1;
        repeat (2 * LAT + 20) @(posedge Fg_CLK);
        #2;
        chk("post_rst_cnt", 32'(n_load), 32'(base + 1));
        chk("post_rst_ftw", FTW, 32'd0);
        chk("post_rst_busy", 32'(Busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
